// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the unified-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_ICACHE = 2'd1,
    OWN_DCACHE = 2'd2
  } owner_t;

  localparam int MEM_LAT_DEF    = 4;
  localparam int STARVE_MAX_DEF = 3;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_select.sv
// Priority select between I-side and D-side requests (D wins ties) with a saturating
// starvation counter that forces an I grant after STARVE_MAX lost ties.
module arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ic_req,
  input  logic   dc_req,
  input  logic   grant,
  output owner_t sel
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  always_comb begin
    sel = OWN_NONE;
    if (ic_req && dc_req && starved) sel = OWN_ICACHE;
    else if (dc_req)                 sel = OWN_DCACHE;
    else if (ic_req)                 sel = OWN_ICACHE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (sel == OWN_ICACHE) starve_cnt <= '0;
      else if (sel == OWN_DCACHE && ic_req && !starved) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory between I-cache and D-cache fills.
// IDLE -> ISSUE -> WAIT -> RESP; done pulses MEM_LAT+2 cycles after the grant cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  output logic [15:0] ic_rdata,
  output logic        ic_done,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [15:0] dc_addr,
  input  logic [15:0] dc_wdata,
  output logic [15:0] dc_rdata,
  output logic        dc_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_stall,
  output logic        arb_busy
);

  state_t      state, next_state;
  owner_t      owner, sel;
  mem_cmd_t    cmd;
  logic [3:0]  lat_cnt;
  logic [15:0] rdata_q;
  logic        grant;

  assign grant = (state == ST_IDLE) && (ic_req || dc_req);

  arb_select #(.STARVE_MAX(STARVE_MAX)) u_select (
    .clk    (clk),
    .rst_n  (rst_n),
    .ic_req (ic_req),
    .dc_req (dc_req),
    .grant  (grant),
    .sel    (sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (grant) next_state = ST_ISSUE;
      ST_ISSUE: if (!mem_stall) next_state = ST_WAIT;
      ST_WAIT:  if (lat_cnt == 4'd0) next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Request fields are captured only at grant; input churn afterwards is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= OWN_NONE;
      cmd     <= '0;
      lat_cnt <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner <= sel;
            if (sel == OWN_DCACHE) cmd <= '{wr: dc_wr, addr: dc_addr, wdata: dc_wdata};
            else                   cmd <= '{wr: 1'b0, addr: ic_addr, wdata: 16'h0000};
          end
        end
        ST_ISSUE: if (!mem_stall) lat_cnt <= 4'(MEM_LAT - 1);
        ST_WAIT: begin
          if (lat_cnt == 4'd0) rdata_q <= cmd.wr ? 16'h0000 : mem_rdata;
          else                 lat_cnt <= lat_cnt - 4'd1;
        end
        ST_RESP: owner <= OWN_NONE;
        default: owner <= OWN_NONE;
      endcase
    end
  end

  always_comb begin
    arb_busy  = (state != ST_IDLE);
    mem_en    = (state == ST_ISSUE);
    mem_wr    = mem_en & cmd.wr;
    mem_addr  = mem_en ? cmd.addr  : 16'h0000;
    mem_wdata = mem_en ? cmd.wdata : 16'h0000;
    ic_done   = (state == ST_RESP) && (owner == OWN_ICACHE);
    dc_done   = (state == ST_RESP) && (owner == OWN_DCACHE);
    ic_rdata  = ic_done ? rdata_q : 16'h0000;
    dc_rdata  = dc_done ? rdata_q : 16'h0000;
  end

endmodule
